// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DEFAULT_SYS_FREQ = 11900000;
  localparam int DEFAULT_BAUD     = 9600;
  localparam int BYTE_W           = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Integer division: the residual baud error is accepted by both ends.
  function automatic int clks_per_bit(input int sys_freq, input int baud);
    return sys_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Valid/ready byte stream feeding the buffered UART transmitter.
interface uart_tx_fifo_if;
  import uart_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO; the head entry is readable combinationally.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   hwclk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [BYTE_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [BYTE_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic [BYTE_W-1:0] mem_r [DEPTH];
  logic              wr_ok_s;
  logic              rd_ok_s;

  // The extra pointer MSB separates full from empty when the indices match.
  assign count   = wr_ptr_r - rd_ptr_r;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == {(AW+1){1'b0}});
  assign wr_ok_s = wr_en && !full;
  assign rd_ok_s = rd_en && !empty;
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update
  always_ff @(posedge hwclk) begin
    if (reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (rd_ok_s) rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage write
  always_ff @(posedge hwclk) begin
    if (wr_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8N2 UART transmitter: byte FIFO in front of a start/data/stop serialiser.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int SYS_FREQ     = DEFAULT_SYS_FREQ,
  parameter int BAUD         = DEFAULT_BAUD,
  parameter int CLKS_PER_BIT = clks_per_bit(SYS_FREQ, BAUD),
  parameter int FIFO_DEPTH   = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                        hwclk,
  input  logic                        reset,
  uart_tx_fifo_if.slave               in_if,
  output logic                        tx_data,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        drop
);

  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);

  tx_state_t         state_r, next_state_s;
  logic [CW-1:0]     cnt_r, cnt_next_s;
  logic [2:0]        bit_idx_r, bit_idx_next_s;
  logic [BYTE_W-1:0] shift_reg_r, shift_next_s;
  logic              tx_data_r, tx_next_s;
  logic              tx_busy_r;
  logic              drop_r;
  logic              pop_s;
  logic [BYTE_W-1:0] head_s;
  logic              full_s;
  logic              empty_s;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .hwclk   (hwclk),
    .reset   (reset),
    .wr_en   (in_if.in_valid),
    .wr_data (in_if.in_data),
    .rd_en   (pop_s),
    .rd_data (head_s),
    .count   (fifo_count),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign in_if.in_ready = !full_s;
  assign tx_data        = tx_data_r;
  assign tx_busy        = tx_busy_r;
  assign drop           = drop_r;

  // Next state, next line level and pop decision; the line value is registered.
  always_comb begin
    next_state_s   = state_r;
    cnt_next_s     = cnt_r + CW'(1);
    bit_idx_next_s = bit_idx_r;
    shift_next_s   = shift_reg_r;
    tx_next_s      = 1'b1;
    pop_s          = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_next_s = {CW{1'b0}};
        if (!empty_s) begin
          pop_s        = 1'b1;
          shift_next_s = head_s;
          next_state_s = START;
          tx_next_s    = 1'b0;
        end else begin
          tx_next_s = 1'b1;
        end
      end
      START: begin
        if (cnt_r == BIT_LAST) begin
          next_state_s   = DATA;
          cnt_next_s     = {CW{1'b0}};
          bit_idx_next_s = 3'd0;
          tx_next_s      = shift_reg_r[0];
        end else begin
          tx_next_s = 1'b0;
        end
      end
      DATA: begin
        tx_next_s = shift_reg_r[0];
        if (cnt_r == BIT_LAST) begin
          cnt_next_s = {CW{1'b0}};
          if (bit_idx_r == 3'd7) begin
            next_state_s = STOP;
            tx_next_s    = 1'b1;
          end else begin
            bit_idx_next_s = bit_idx_r + 3'd1;
            shift_next_s   = {1'b0, shift_reg_r[BYTE_W-1:1]};
            tx_next_s      = shift_reg_r[1];
          end
        end else begin
          tx_next_s = shift_reg_r[0];
        end
      end
      STOP: begin
        tx_next_s = 1'b1;
        if (cnt_r == STOP_LAST) begin
          cnt_next_s = {CW{1'b0}};
          if (!empty_s) begin
            pop_s        = 1'b1;
            shift_next_s = head_s;
            next_state_s = START;
            tx_next_s    = 1'b0;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          tx_next_s = 1'b1;
        end
      end
      default: begin
        next_state_s = IDLE;
        cnt_next_s   = {CW{1'b0}};
        tx_next_s    = 1'b1;
      end
    endcase
  end

  // State, timing and output registers
  always_ff @(posedge hwclk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      bit_idx_r   <= 3'd0;
      shift_reg_r <= {BYTE_W{1'b0}};
      tx_data_r   <= 1'b1;
      tx_busy_r   <= 1'b0;
      drop_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      cnt_r       <= cnt_next_s;
      bit_idx_r   <= bit_idx_next_s;
      shift_reg_r <= shift_next_s;
      tx_data_r   <= tx_next_s;
      tx_busy_r   <= (next_state_s != IDLE);
      drop_r      <= in_if.in_valid && full_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 16 clk/bit 8N1 and 8N2 instances plus a default-rate instance.
module tb_uart_tx_fifo;

  logic hwclk;
  logic reset_a, reset_bc;
  logic tx_a, busy_a, drop_a;
  logic tx_b, busy_b, drop_b;
  logic tx_c, busy_c, drop_c;
  logic [3:0] cnt_a, cnt_b, cnt_c;
  int n_checks, n_errors;

  uart_tx_fifo_if if_a ();
  uart_tx_fifo_if if_b ();
  uart_tx_fifo_if if_c ();

  uart_tx_fifo #(.SYS_FREQ(16), .BAUD(1), .STOP_BITS(1)) dut_a (
    .hwclk(hwclk), .reset(reset_a), .in_if(if_a),
    .tx_data(tx_a), .tx_busy(busy_a), .fifo_count(cnt_a), .drop(drop_a));

  uart_tx_fifo #(.SYS_FREQ(16), .BAUD(1), .STOP_BITS(2)) dut_b (
    .hwclk(hwclk), .reset(reset_bc), .in_if(if_b),
    .tx_data(tx_b), .tx_busy(busy_b), .fifo_count(cnt_b), .drop(drop_b));

  uart_tx_fifo dut_c (
    .hwclk(hwclk), .reset(reset_bc), .in_if(if_c),
    .tx_data(tx_c), .tx_busy(busy_c), .fifo_count(cnt_c), .drop(drop_c));

  always #5 hwclk = ~hwclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge hwclk);
  endtask

  function automatic logic tx_of(input int sel);
    case (sel)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic push(input int sel, input logic [7:0] d);
    case (sel)
      0:       begin if_a.in_data = d; if_a.in_valid = 1'b1; end
      1:       begin if_b.in_data = d; if_b.in_valid = 1'b1; end
      default: begin if_c.in_data = d; if_c.in_valid = 1'b1; end
    endcase
  endtask

  task automatic idle_all();
    if_a.in_valid = 1'b0; if_b.in_valid = 1'b0; if_c.in_valid = 1'b0;
    if_a.in_data  = 8'h00; if_b.in_data = 8'h00; if_c.in_data = 8'h00;
  endtask

  // Walks a frame from cycle 'offset' onward; one check per bit on cycles matching the expected level.
  task automatic check_frame(input int sel, input logic [7:0] b, input int stops, input int cpb,
                             input int offset, input string tag, output int busy_cycles);
    logic exp_bit;
    int good, seen;
    busy_cycles = 0;
    for (int k = 0; k < 9 + stops; k++) begin
      exp_bit = (k == 0) ? 1'b0 : ((k <= 8) ? b[k-1] : 1'b1);
      good = 0;
      seen = 0;
      for (int c = k * cpb; c < (k + 1) * cpb; c++) begin
        if (c >= offset) begin
          seen++;
          if (tx_of(sel) === exp_bit) good++;
          if (busy_of(sel) === 1'b1) busy_cycles++;
          tick();
        end
      end
      check_eq($sformatf("%s_bit%0d", tag, k), good, seen);
    end
  endtask

  int bc, total, t, hi, lo;
  logic prev;
  logic found;
  int exp_cnt [10];

  initial begin
    hwclk = 1'b0; n_checks = 0; n_errors = 0;
    reset_a = 1'b1; reset_bc = 1'b1;
    idle_all();
    repeat (2) tick();
    check_eq("rst_tx", tx_a, 1);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_cnt", cnt_a, 0);
    check_eq("rst_drop", drop_a, 0);
    check_eq("rst_ready", if_a.in_ready, 1);
    reset_a = 1'b0; reset_bc = 1'b0;
    tick();

    // Single 0x55 frame: start bit two edges after the push, 160 busy cycles
    push(0, 8'h55); tick(); idle_all();
    check_eq("s1_cnt1", cnt_a, 1);
    check_eq("s1_tx_pre", tx_a, 1);
    tick();
    check_eq("s1_cnt0", cnt_a, 0);
    check_frame(0, 8'h55, 1, 16, 0, "s1", bc);
    check_eq("s1_busy_len", bc, 160);
    check_eq("s1_idle_tx", tx_a, 1);
    check_eq("s1_idle_busy", busy_a, 0);

    // Three back-to-back frames
    push(0, 8'h41); tick(); check_eq("s2_cnt_a", cnt_a, 1);
    push(0, 8'h42); tick(); check_eq("s2_cnt_b", cnt_a, 1);
    check_eq("s2_busy0", busy_a, 1);
    push(0, 8'h43); tick(); check_eq("s2_cnt_c", cnt_a, 2);
    idle_all();
    check_frame(0, 8'h41, 1, 16, 1, "s2f0", bc); total = bc + 1;
    check_eq("s2_cnt_f1", cnt_a, 1);
    check_frame(0, 8'h42, 1, 16, 0, "s2f1", bc); total += bc;
    check_eq("s2_cnt_f2", cnt_a, 0);
    check_frame(0, 8'h43, 1, 16, 0, "s2f2", bc); total += bc;
    check_eq("s2_total", total, 480);
    check_eq("s2_idle_tx", tx_a, 1);
    check_eq("s2_idle_busy", busy_a, 0);

    // Overfill: ten pushes into an eight-entry FIFO while the first frame starts
    exp_cnt = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 8};
    for (int i = 0; i < 10; i++) begin
      push(0, 8'(i)); tick();
      check_eq($sformatf("s3_cnt%0d", i), cnt_a, exp_cnt[i]);
    end
    check_eq("s3_ready", if_a.in_ready, 0);
    check_eq("s3_drop_hi", drop_a, 1);
    idle_all(); tick();
    check_eq("s3_drop_lo", drop_a, 0);
    check_frame(0, 8'h00, 1, 16, 9, "s3f0", bc);
    for (int i = 1; i < 9; i++) begin
      check_frame(0, 8'(i), 1, 16, 0, $sformatf("s3f%0d", i), bc);
    end
    check_eq("s3_end_busy", busy_a, 0);
    check_eq("s3_end_cnt", cnt_a, 0);

    // Reset during the third data bit discards the frame and the queued byte
    push(0, 8'hA5); tick(); idle_all(); tick();
    repeat (20) tick();
    push(0, 8'h77); tick(); idle_all();
    check_eq("s4_cnt_q", cnt_a, 1);
    repeat (28) tick();
    check_eq("s4_bit2", tx_a, 1);
    check_eq("s4_busy_pre", busy_a, 1);
    reset_a = 1'b1; tick(); reset_a = 1'b0;
    check_eq("s4_rst_tx", tx_a, 1);
    check_eq("s4_rst_busy", busy_a, 0);
    check_eq("s4_rst_cnt", cnt_a, 0);
    repeat (40) tick();
    check_eq("s4_quiet_busy", busy_a, 0);
    check_eq("s4_quiet_tx", tx_a, 1);
    push(0, 8'h3C); tick(); idle_all(); tick();
    check_frame(0, 8'h3C, 1, 16, 0, "s4f", bc);
    check_eq("s4_busy_len", bc, 160);

    // Two stop bits: falling edges 176 cycles apart, 32-cycle stop high
    push(1, 8'hFF); tick(); push(1, 8'h00); tick(); idle_all();
    check_eq("s5_start", tx_b, 0);
    t = 0; prev = tx_b; found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      tick(); t++;
      if (prev === 1'b1 && tx_b === 1'b0) found = 1'b1;
      prev = tx_b;
    end
    check_eq("s5_fall_found", found, 1);
    check_eq("s5_fall_gap", t, 176);
    hi = 0; lo = 0;
    for (int k = 0; k < 200; k++) begin
      if (busy_b === 1'b1 && tx_b === 1'b1) hi++;
      if (busy_b === 1'b1 && tx_b === 1'b0) lo++;
      tick();
    end
    check_eq("s5_stop_hi", hi, 32);
    check_eq("s5_low", lo, 144);
    check_eq("s5_end_busy", busy_b, 0);

    // Default rate: 1239 clocks per bit, 12390-cycle frame
    push(2, 8'h0D); tick(); idle_all(); tick();
    check_frame(2, 8'h0D, 1, 1239, 0, "s6", bc);
    check_eq("s6_busy_len", bc, 12390);
    check_eq("s6_end_tx", tx_c, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
